// File: rtl/regfile_port_master.sv
// Bulk register-file initiator: streams registers out (DUMP), streams words in (LOAD)
// or writes one constant over a range (FILL), owning the write port and read port A while busy.
module regfile_port_master #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_len,
  input  logic [DW-1:0] cmd_fill,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  output logic          dp_valid,
  input  logic          dp_ready,
  output logic [AW-1:0] dp_addr,
  output logic [DW-1:0] dp_data,
  output logic          RegWrite,
  output logic [AW-1:0] wrAddr,
  output logic [DW-1:0] wrData,
  output logic [AW-1:0] rdAddrA,
  input  logic [DW-1:0] rdDataA,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] OpDump = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpFill = 2'b10;
  localparam logic [1:0] OpRsvd = 2'b11;

  typedef enum logic [2:0] {IDLE, DUMP, LOAD, FILL, FIN} stateType;

  stateType      state, stateNext;
  logic [AW-1:0] ptr, ptrNext;
  logic [AW:0]   remain, remainNext;
  logic          regWriteNext;
  logic [AW-1:0] wrAddrNext;
  logic [DW-1:0] wrDataNext;
  logic [AW-1:0] rdAddrNext;
  logic          dpValidNext;
  logic [AW-1:0] dpAddrNext;
  logic [DW-1:0] dpDataNext;

  function automatic logic [AW-1:0] nextAddr(input logic [AW-1:0] a);
    return (a == AW'(NREG - 1)) ? '0 : a + AW'(1);
  endfunction

  // Gating with reset keeps cmd_ready low while reset is held, so nothing is accepted then.
  assign cmd_ready = (state == IDLE) && reset;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign ld_ready  = (state == LOAD);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Every transfer's last register-file write lands in FIN, so done always coincides with it.
  always_comb begin
    stateNext    = state;
    ptrNext      = ptr;
    remainNext   = remain;
    regWriteNext = 1'b0;
    wrAddrNext   = wrAddr;
    wrDataNext   = wrData;
    rdAddrNext   = rdAddrA;
    dpValidNext  = dp_valid;
    dpAddrNext   = dp_addr;
    dpDataNext   = dp_data;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_len == '0 || cmd_op == OpRsvd) begin
            stateNext = FIN;
          end else begin
            case (cmd_op)
              OpFill: begin
                regWriteNext = 1'b1;
                wrAddrNext   = cmd_base;
                wrDataNext   = cmd_fill;
                ptrNext      = nextAddr(cmd_base);
                remainNext   = cmd_len - (AW+1)'(1);
                stateNext    = (cmd_len == (AW+1)'(1)) ? FIN : FILL;
              end
              OpLoad: begin
                ptrNext    = cmd_base;
                remainNext = cmd_len;
                stateNext  = LOAD;
              end
              default: begin
                rdAddrNext = cmd_base;
                remainNext = cmd_len;
                stateNext  = DUMP;
              end
            endcase
          end
        end
      end
      FILL: begin
        regWriteNext = 1'b1;
        wrAddrNext   = ptr;
        ptrNext      = nextAddr(ptr);
        remainNext   = remain - (AW+1)'(1);
        if (remain == (AW+1)'(1)) stateNext = FIN;
      end
      LOAD: begin
        if (ld_valid) begin
          regWriteNext = 1'b1;
          wrAddrNext   = ptr;
          wrDataNext   = ld_data;
          ptrNext      = nextAddr(ptr);
          remainNext   = remain - (AW+1)'(1);
          if (remain == (AW+1)'(1)) stateNext = FIN;
        end
      end
      DUMP: begin
        if (!dp_valid || dp_ready) begin
          if (remain != '0) begin
            dpValidNext = 1'b1;
            dpAddrNext  = rdAddrA;
            dpDataNext  = rdDataA;
            rdAddrNext  = nextAddr(rdAddrA);
            remainNext  = remain - (AW+1)'(1);
          end else begin
            dpValidNext = 1'b0;
            stateNext   = FIN;
          end
        end
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr      <= '0;
      remain   <= '0;
      RegWrite <= 1'b0;
      wrAddr   <= '0;
      wrData   <= '0;
      rdAddrA  <= '0;
      dp_valid <= 1'b0;
      dp_addr  <= '0;
      dp_data  <= '0;
    end else begin
      ptr      <= ptrNext;
      remain   <= remainNext;
      RegWrite <= regWriteNext;
      wrAddr   <= wrAddrNext;
      wrData   <= wrDataNext;
      rdAddrA  <= rdAddrNext;
      dp_valid <= dpValidNext;
      dp_addr  <= dpAddrNext;
      dp_data  <= dpDataNext;
    end
  end

endmodule

// File: tb/tb_regfile_port_master.sv
// Bench for regfile_port_master: a table of directed commands plus random commands,
// checked against a transaction-level model of the register file and of each bulk operation.
module tb_regfile_port_master;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic [DW-1:0] cmd_fill;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          dp_valid;
  logic          dp_ready;
  logic [AW-1:0] dp_addr;
  logic [DW-1:0] dp_data;
  logic          RegWrite;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [AW-1:0] rdAddrA;
  logic [DW-1:0] rdDataA;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] rf      [NREG];
  logic [DW-1:0] gold    [NREG];
  logic [DW-1:0] preVal  [NREG];
  logic          preload = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  base;
    logic [5:0]  len;
    logic [31:0] fill;
    logic [31:0] w0;
    logic [31:0] w1;
    int          ldGap;
    int          dpStall;
    int          expDoneLat;
  } vecT;

  vecT tbl [12];

  regfile_port_master #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_addr(dp_addr), .dp_data(dp_data),
    .RegWrite(RegWrite), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdDataA(rdDataA), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read A, write on the rising edge.
  assign rdDataA = rf[rdAddrA];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NREG; i++) rf[i] <= preVal[i];
    end else if (RegWrite) begin
      rf[wrAddr] <= wrData;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRegFile(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < NREG; i++) if (rf[i] !== gold[i]) bad++;
    checkOutput(name, bad, 0);
  endtask

  // Runs one command end to end and compares what it did against the model.
  task automatic applyStimulus(input vecT v, input bit rnd, input string tag);
    logic [31:0] words[$];
    int          expAddr[$];
    logic [31:0] expData[$];
    int          gotAddr[$];
    logic [31:0] gotData[$];
    int          n, cyc, doneCyc, doneCnt, idx, gap, stall, a;
    bit          hsPrev, hsThis, illegal, stallBad, lateWrite, finished, rdy, vld, holdPending;
    logic [4:0]  heldAddr;
    logic [31:0] heldData;

    n = (v.op == 2'b11) ? 0 : int'(v.len);
    for (int i = 0; i < n; i++) words.push_back(i == 0 ? v.w0 : (i == 1 ? v.w1 : $urandom));
    for (int i = 0; i < n; i++) begin
      a = (int'(v.base) + i) % NREG;
      expAddr.push_back(a);
      case (v.op)
        2'b10:   expData.push_back(v.fill);
        2'b01:   expData.push_back(words[i]);
        default: expData.push_back(gold[a]);
      endcase
    end

    @(negedge clk);
    checkOutput({tag, " cmd_ready idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_base = v.base; cmd_len = v.len; cmd_fill = v.fill;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    cyc = 0; doneCyc = -1; doneCnt = 0; idx = 0; gap = 0; stall = v.dpStall;
    hsPrev = 1'b0; illegal = 1'b0; stallBad = 1'b0; lateWrite = 1'b0; finished = 1'b0;
    holdPending = 1'b0; heldAddr = '0; heldData = '0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (doneCyc >= 0 && cyc > doneCyc) begin
        checkOutput({tag, " busy after done"}, busy, 0);
        checkOutput({tag, " cmd_ready after done"}, cmd_ready, 1);
        if (RegWrite || dp_valid) illegal = 1'b1;
        finished = 1'b1;
        break;
      end
      if (RegWrite) begin gotAddr.push_back(int'(wrAddr)); gotData.push_back(wrData); end
      if (v.op == 2'b00 && RegWrite) illegal = 1'b1;
      if (v.op != 2'b00 && dp_valid) illegal = 1'b1;
      if (v.op != 2'b01 && ld_ready) illegal = 1'b1;
      if (n == 0 && (RegWrite || dp_valid || ld_ready)) illegal = 1'b1;
      if (v.op == 2'b01 && RegWrite != hsPrev) lateWrite = 1'b1;
      if (holdPending && (!dp_valid || dp_addr !== heldAddr || dp_data !== heldData)) stallBad = 1'b1;
      if (v.op == 2'b00 && n > 0 && cyc == 1) checkOutput({tag, " rdAddrA first"}, rdAddrA, v.base);
      if (done) begin doneCnt++; if (doneCyc < 0) doneCyc = cyc; end

      hsThis = 1'b0;
      if (ld_ready && idx < n) begin
        if (rnd) vld = ($urandom % 4) != 0;
        else if (gap > 0) begin vld = 1'b0; gap--; end
        else vld = 1'b1;
        ld_valid = vld;
        ld_data  = vld ? words[idx] : $urandom;
        if (vld) begin hsThis = 1'b1; idx++; gap = v.ldGap; end
      end else begin
        ld_valid = 1'b0;
      end
      hsPrev = hsThis;

      if (rnd) rdy = ($urandom % 3) != 0;
      else if (dp_valid && stall > 0) begin rdy = 1'b0; stall--; end
      else rdy = 1'b1;
      dp_ready = rdy;
      if (dp_valid && rdy) begin gotAddr.push_back(int'(dp_addr)); gotData.push_back(dp_data); end
      holdPending = dp_valid && !rdy;
      heldAddr = dp_addr;
      heldData = dp_data;
    end
    ld_valid = 1'b0;
    dp_ready = 1'b0;

    checkOutput({tag, " completed in budget"}, finished, 1);
    checkOutput({tag, " transfer count"}, gotAddr.size(), expAddr.size());
    for (int i = 0; i < n && i < gotAddr.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), gotAddr[i], expAddr[i]);
      checkOutput($sformatf("%s data[%0d]", tag, i), gotData[i], expData[i]);
    end
    checkOutput({tag, " done pulses"}, doneCnt, 1);
    checkOutput({tag, " illegal activity"}, illegal, 0);
    checkOutput({tag, " dump hold"}, stallBad, 0);
    checkOutput({tag, " load write timing"}, lateWrite, 0);
    if (v.expDoneLat >= 0) checkOutput({tag, " done latency"}, doneCyc, v.expDoneLat);

    if (v.op == 2'b10 || v.op == 2'b01)
      for (int i = 0; i < n; i++) gold[expAddr[i]] = expData[i];
    checkRegFile({tag, " regfile"});
  endtask

  initial begin
    vecT rv;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_len = '0; cmd_fill = '0;
    ld_valid = 1'b0; ld_data = '0; dp_ready = 1'b0;

    tbl[0]  = '{2'b10, 5'd30, 6'd4,  32'hDEADBEEF, 32'h0,  32'h0, 0, 0, 4};
    tbl[1]  = '{2'b01, 5'd10, 6'd2,  32'h0,        32'h15, 32'h3, 2, 0, 5};
    tbl[2]  = '{2'b00, 5'd10, 6'd2,  32'h0,        32'h0,  32'h0, 0, 3, 7};
    tbl[3]  = '{2'b10, 5'd0,  6'd0,  32'h11111111, 32'h0,  32'h0, 0, 0, 1};
    tbl[4]  = '{2'b01, 5'd5,  6'd0,  32'h0,        32'h0,  32'h0, 0, 0, 1};
    tbl[5]  = '{2'b00, 5'd9,  6'd0,  32'h0,        32'h0,  32'h0, 0, 0, 1};
    tbl[6]  = '{2'b11, 5'd2,  6'd5,  32'h22222222, 32'h0,  32'h0, 0, 0, 1};
    tbl[7]  = '{2'b10, 5'd31, 6'd1,  32'h12345678, 32'h0,  32'h0, 0, 0, 1};
    tbl[8]  = '{2'b01, 5'd0,  6'd32, 32'h0,        32'h7,  32'h9, 0, 0, 33};
    tbl[9]  = '{2'b00, 5'd5,  6'd32, 32'h0,        32'h0,  32'h0, 0, 0, 34};
    tbl[10] = '{2'b10, 5'd7,  6'd32, 32'hCAFEF00D, 32'h0,  32'h0, 0, 0, 32};
    tbl[11] = '{2'b00, 5'd30, 6'd4,  32'h0,        32'h0,  32'h0, 0, 1, 7};

    for (int i = 0; i < NREG; i++) begin preVal[i] = $urandom; gold[i] = preVal[i]; end
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0; reset = 1'b1;
    @(negedge clk);
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset idle outputs", {busy, done, RegWrite, dp_valid, ld_ready, wrAddr, rdAddrA}, 0);
    checkRegFile("preload regfile");

    // Abort: reset lands after the second FILL write.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_base = 5'd30; cmd_len = 6'd4; cmd_fill = 32'h0BADF00D;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort write1", {RegWrite, wrAddr}, {1'b1, 5'd30});
    @(negedge clk);
    checkOutput("abort write2", {RegWrite, wrAddr}, {1'b1, 5'd31});
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort held ctl %0d", k),
                  {busy, done, RegWrite, dp_valid, ld_ready, wrAddr, rdAddrA, dp_addr}, 0);
      checkOutput($sformatf("abort held data %0d", k), {wrData, dp_data}, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release cmd_ready", cmd_ready, 1);
    checkOutput("release busy/done", {busy, done}, 0);
    gold[30] = 32'h0BADF00D;
    gold[31] = 32'h0BADF00D;
    checkRegFile("abort regfile");

    for (int i = 0; i < 12; i++) applyStimulus(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Reserved op while a second command waits: the waiting one starts only after IDLE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_base = 5'd2; cmd_len = 6'd5; cmd_fill = '0;
    @(posedge clk);
    #1 cmd_op = 2'b10; cmd_base = 5'd3; cmd_len = 6'd2; cmd_fill = 32'hA5A5A5A5;
    @(negedge clk);
    checkOutput("busy-ignore fin", {done, busy, cmd_ready, RegWrite}, 4'b1100);
    @(negedge clk);
    checkOutput("busy-ignore idle", {done, busy, cmd_ready, RegWrite}, 4'b0010);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy-ignore w1", {RegWrite, wrAddr, wrData, done}, {1'b1, 5'd3, 32'hA5A5A5A5, 1'b0});
    @(negedge clk);
    checkOutput("busy-ignore w2", {RegWrite, wrAddr, wrData, done}, {1'b1, 5'd4, 32'hA5A5A5A5, 1'b1});
    @(negedge clk);
    gold[3] = 32'hA5A5A5A5;
    gold[4] = 32'hA5A5A5A5;
    checkRegFile("busy-ignore regfile");

    for (int t = 0; t < 40; t++) begin
      rv.op = 2'($urandom_range(0, 3));
      if (rv.op == 2'b11 && ($urandom % 2) == 0) rv.op = 2'b00;
      rv.base = 5'($urandom_range(0, 31));
      rv.len  = 6'($urandom_range(0, 32));
      rv.fill = $urandom; rv.w0 = $urandom; rv.w1 = $urandom;
      rv.ldGap = 0; rv.dpStall = 0; rv.expDoneLat = -1;
      applyStimulus(rv, 1'b1, $sformatf("rnd%0d", t));
    end

    checkRegFile("final regfile");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
